multi_clock_divider: RTL and testbench

MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

---
 rtl/multi_clock_divider.sv | 118 +++++++++++
 tb/tb_multi_clock_divider.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// Bank of NUM_CH independent 50%-duty clock dividers with glitch-free, rollover-aligned reprogramming.
// Optional MULTI_CLKDIV_SYNC_EN adds sync_in, which zeroes every counter and output to phase-align all channels.
module multi_clock_divider #(
    parameter int NUM_CH       = 4,
    parameter int WIDTH        = 23,
    parameter int DEFAULT_HALF = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_in,
    input  logic              reset,
`ifdef MULTI_CLKDIV_SYNC_EN
    input  logic              sync_in,
`endif
    input  logic              wr_valid,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WIDTH-1:0]  wr_half,
    output logic              wr_ready,
    output logic              wr_err,
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [WIDTH-1:0] DEF_HALF = WIDTH'(DEFAULT_HALF);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic              sel_pending;
    logic              wr_in_range;
    logic [NUM_CH-1:0] wr_hit;

    // Out-of-range channels are always ready so a stray write can never stall the bus.
    always_comb begin
        sel_pending = 1'b0;
        wr_in_range = 1'b0;
        wr_hit      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ch == CH_W'(i)) begin
                wr_in_range = 1'b1;
                sel_pending = pending[i];
                wr_hit[i]   = wr_valid && !pending[i];
            end
        end
    end

    assign wr_ready = !sel_pending;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_valid && !wr_in_range;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] active_half;
        logic [WIDTH-1:0] pending_half;
        logic [WIDTH-1:0] cnt;
        logic             out_q;
        logic             out_d1;
        logic             tick_q;
        logic             pend_q;
        logic             running;
        logic             at_roll;

        assign running = (active_half != '0);
        assign at_roll = running && (cnt == active_half - ONE);

        always_ff @(posedge clock_in or posedge reset) begin
            if (reset) begin
                active_half  <= DEF_HALF;
                pending_half <= DEF_HALF;
                cnt          <= '0;
                out_q        <= 1'b0;
                out_d1       <= 1'b0;
                tick_q       <= 1'b0;
                pend_q       <= 1'b0;
            end else begin
                // tick is derived from the registered output, so it lags the rising edge by one cycle
                out_d1 <= out_q;
                tick_q <= out_q && !out_d1;

                if (wr_hit[g]) begin
                    pending_half <= wr_half;
                    pend_q       <= 1'b1;
                end

`ifdef MULTI_CLKDIV_SYNC_EN
                if (sync_in) begin
                    cnt   <= '0;
                    out_q <= 1'b0;
                end else
`endif
                if (pend_q && (!running || at_roll)) begin
                    active_half <= pending_half;
                    cnt         <= '0;
                    pend_q      <= 1'b0;
                    // stopping forces low; starting from stopped waits a full half-period before rising
                    if (pending_half == '0) begin
                        out_q <= 1'b0;
                    end else if (at_roll) begin
                        out_q <= !out_q;
                    end
                end else if (at_roll) begin
                    cnt   <= '0;
                    out_q <= !out_q;
                end else if (running) begin
                    cnt <= cnt + ONE;
                end
            end
        end

        assign clock_out[g] = out_q;
        assign tick[g]      = tick_q;
        assign pending[g]   = pend_q;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: tick/wr_err pulses go through an expected-event queue checked by a monitor.
// Built with NUM_CH=3 so the 2-bit wr_ch can address a non-existent channel (3).
module tb_multi_clock_divider;

    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int DH  = 3;

    logic           clock_in;
    logic           reset;
`ifdef MULTI_CLKDIV_SYNC_EN
    logic           sync_in;
`endif
    logic           wr_valid;
    logic [1:0]     wr_ch;
    logic [W-1:0]   wr_half;
    logic           wr_ready;
    logic           wr_err;
    logic [NCH-1:0] clock_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;

    multi_clock_divider #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_HALF(DH)) dut (
        .clock_in  (clock_in),
        .reset     (reset),
`ifdef MULTI_CLKDIV_SYNC_EN
        .sync_in   (sync_in),
`endif
        .wr_valid  (wr_valid),
        .wr_ch     (wr_ch),
        .wr_half   (wr_half),
        .wr_ready  (wr_ready),
        .wr_err    (wr_err),
        .clock_out (clock_out),
        .tick      (tick),
        .pending   (pending)
    );

    typedef struct {
        int cyc;
        int ch;   // NCH means wr_err
    } ev_t;

    ev_t            sb[$];
    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    logic [NCH-1:0] mon_mask = '0;

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // cyc = number of rising edges seen with reset low
    always @(posedge clock_in) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cycle(input int n);
        int guard = 0;
        while (cyc < n && guard < 500) begin
            @(negedge clock_in);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            failures++;
            $display("FAIL wait_cycle actual=%0d required=%0d", cyc, n);
        end
    endtask

    task automatic push(input int c, input int ch);
        ev_t e;
        e.cyc = c;
        e.ch  = ch;
        sb.push_back(e);
    endtask

    // Monitor: every observed pulse must be the queue head; anything left behind the current cycle was missed.
    always begin
        logic obs;
        @(posedge clock_in);
        #2;
        if (!reset) begin
            for (int c = 0; c <= NCH; c++) begin
                obs = (c == NCH) ? wr_err : (mon_mask[c] && tick[c]);
                if (obs) begin
                    checks++;
                    if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].ch == c) begin
                        void'(sb.pop_front());
                    end else begin
                        failures++;
                        $display("FAIL unexpected_pulse ch=%0d actual_cycle=%0d required_cycle=%0d",
                                 c, cyc, (sb.size() > 0) ? sb[0].cyc : -1);
                    end
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_pulse ch=%0d actual=none required_cycle=%0d", sb[0].ch, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_half  = '0;
`ifdef MULTI_CLKDIV_SYNC_EN
        sync_in  = 1'b0;
`endif
        mon_mask = 3'b111;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NCH; c++) push(4 + 6 * k, c);
        end

        repeat (3) @(negedge clock_in);
        chk("rst_clock_out", int'(clock_out), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_wr_err", int'(wr_err), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        reset = 1'b0;

        // Default half=3 on all channels
        wait_cycle(2);  chk("def_c2", int'(clock_out), 0);
        wait_cycle(3);  chk("def_rise_c3", int'(clock_out), 7);
        wait_cycle(5);  chk("def_c5", int'(clock_out), 7);
        wait_cycle(6);  chk("def_fall_c6", int'(clock_out), 0);
        wait_cycle(9);  chk("def_rise_c9", int'(clock_out), 7);

        // ch1 -> half 5, accepted on its rollover edge 18, applied at 21
        wait_cycle(17);
        mon_mask = 3'b010;
        push(22, 1); push(32, 1); push(36, 1); push(40, 1);
        wr_valid = 1'b1; wr_ch = 2'd1; wr_half = 8'd5;
        wait_cycle(18);
        wr_valid = 1'b0;
        chk("ch1_pend_c18", int'(pending), 2);
        chk("ch1_out_c18", int'(clock_out[1]), 0);
        wait_cycle(20); chk("ch1_pend_c20", int'(pending[1]), 1);
        wait_cycle(21);
        chk("ch1_pend_c21", int'(pending[1]), 0);
        chk("ch1_out_c21", int'(clock_out[1]), 1);
        wait_cycle(25); chk("ch1_out_c25", int'(clock_out[1]), 1);
        wait_cycle(26); chk("ch1_out_c26", int'(clock_out[1]), 0);

        // ch1 -> half 2 mid-period
        wait_cycle(27);
        #1 chk("ch1_ready_c27", int'(wr_ready), 1);
        wr_valid = 1'b1; wr_half = 8'd2;
        wait_cycle(28);
        wr_valid = 1'b0;
        chk("ch1_pend_c28", int'(pending[1]), 1);
        #1 chk("ch1_ready_c28", int'(wr_ready), 0);
        wait_cycle(30);
        chk("ch1_out_c30", int'(clock_out[1]), 0);
        chk("ch1_pend_c30", int'(pending[1]), 1);
        wait_cycle(31);
        chk("ch1_out_c31", int'(clock_out[1]), 1);
        chk("ch1_pend_c31", int'(pending[1]), 0);
        wait_cycle(33); chk("ch1_out_c33", int'(clock_out[1]), 0);
        wait_cycle(35); chk("ch1_out_c35", int'(clock_out[1]), 1);

        // ch2 -> half 4, then stop while high, then half 1
        wait_cycle(41);
        mon_mask = 3'b100;
        push(46, 2); push(54, 2); push(68, 2); push(70, 2); push(72, 2);
        wr_valid = 1'b1; wr_ch = 2'd2; wr_half = 8'd4;
        wait_cycle(42);
        wr_valid = 1'b0;
        chk("ch2_pend_c42", int'(pending[2]), 1);
        wait_cycle(44);
        chk("ch2_pend_c44", int'(pending[2]), 1);
        chk("ch2_out_c44", int'(clock_out[2]), 0);
        wait_cycle(45);
        chk("ch2_out_c45", int'(clock_out[2]), 1);
        chk("ch2_pend_c45", int'(pending[2]), 0);
        wait_cycle(48); chk("ch2_out_c48", int'(clock_out[2]), 1);
        wait_cycle(49); chk("ch2_out_c49", int'(clock_out[2]), 0);
        wait_cycle(54);
        chk("ch2_out_c54", int'(clock_out[2]), 1);
        wr_valid = 1'b1; wr_half = 8'd0;
        wait_cycle(55);
        wr_valid = 1'b0;
        chk("ch2_pend_c55", int'(pending[2]), 1);
        wait_cycle(57);
        chk("ch2_out_c57", int'(clock_out[2]), 0);
        chk("ch2_pend_c57", int'(pending[2]), 0);
        wait_cycle(61); chk("ch2_stop_c61", int'(clock_out[2]), 0);
        wait_cycle(64);
        chk("ch2_stop_c64", int'(clock_out[2]), 0);
        wr_valid = 1'b1; wr_half = 8'd1;
        wait_cycle(65);
        wr_valid = 1'b0;
        chk("ch2_pend_c65", int'(pending[2]), 1);
        wait_cycle(66);
        chk("ch2_out_c66", int'(clock_out[2]), 0);
        chk("ch2_pend_c66", int'(pending[2]), 0);
        wait_cycle(67); chk("ch2_out_c67", int'(clock_out[2]), 1);
        wait_cycle(68); chk("ch2_out_c68", int'(clock_out[2]), 0);
        wait_cycle(69); chk("ch2_out_c69", int'(clock_out[2]), 1);
        wait_cycle(72);
        mon_mask = 3'b000;

        // Out-of-range write to channel 3
        wait_cycle(75);
        push(76, NCH);
        wr_valid = 1'b1; wr_ch = 2'd3; wr_half = 8'd7;
        #1 chk("oor_ready", int'(wr_ready), 1);
        wait_cycle(76);
        wr_valid = 1'b0;
        chk("oor_pend_c76", int'(pending), 0);
        chk("oor_out_c76", int'(clock_out), 3);
        wait_cycle(77);
        chk("oor_out_c77", int'(clock_out), 5);
        chk("oor_err_c77", int'(wr_err), 0);

        // Async reset mid-count with ch0 pending
        wait_cycle(79);
        wr_valid = 1'b1; wr_ch = 2'd0; wr_half = 8'd9;
        wait_cycle(80);
        wr_valid = 1'b0;
        chk("ar_pend_before", int'(pending), 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_out", int'(clock_out), 0);
        chk("ar_pend", int'(pending), 0);
        chk("ar_tick", int'(tick), 0);
        repeat (2) @(negedge clock_in);
        reset = 1'b0;
        wait_cycle(2); chk("ar_c2", int'(clock_out), 0);
        wait_cycle(3); chk("ar_rise_c3", int'(clock_out), 7);
`ifdef MULTI_CLKDIV_SYNC_EN
        wait_cycle(4);
        sync_in = 1'b1;
        wait_cycle(5);
        sync_in = 1'b0;
        chk("sync_c5", int'(clock_out), 0);
        wait_cycle(7); chk("sync_c7", int'(clock_out), 0);
        wait_cycle(8); chk("sync_rise_c8", int'(clock_out), 7);
`else
        wait_cycle(5); chk("ar_c5", int'(clock_out), 7);
        wait_cycle(6); chk("ar_fall_c6", int'(clock_out), 0);
        wait_cycle(8); chk("ar_c8", int'(clock_out), 0);
`endif
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
